cm_sort_ser: RTL

- Downstream companion of the sorting network: takes one sorted vector of DCNT words and emits the first KCNT words one at a time on a valid/ready stream.
- Supports ascending or descending emission order.
- The sorter has no backpressure. This block therefore accepts a vector only when it can hold it, and counts vectors it has to drop.

---
 rtl/cm_sort_ser.sv | 113 +++++++++++
 1 files changed

// File: rtl/cm_sort_ser.sv
// Serialises the first KCNT words of a sorted DCNT-word vector onto a valid/ready stream.
// One-cycle capture latency; vectors that arrive while the block cannot accept them are dropped and counted.
module cm_sort_ser #(
    parameter int DCNT   = 4,
    parameter int DWIDTH = 8,
    parameter int KCNT   = 4,
    parameter int DESC   = 0,
    parameter int CNT_W  = 16,
    localparam int IW    = (DCNT > 2) ? $clog2(DCNT) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vld,
    input  logic [DCNT-1:0][DWIDTH-1:0]  i_data,
    output logic                         o_rdy,
    output logic                         o_vld,
    input  logic                         i_rdy,
    output logic [DWIDTH-1:0]            o_data,
    output logic [IW-1:0]                o_idx,
    output logic                         o_last,
    output logic                         o_drop,
    output logic [CNT_W-1:0]             o_drop_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state, state_nxt;
    logic [IW-1:0]               k, k_nxt;
    logic [DCNT-1:0][DWIDTH-1:0] hold;
    logic                        capture, advance, drop, xfer;

    // Maps the word counter onto a source position according to emission order.
    function automatic logic [IW-1:0] idx_of(input logic [IW-1:0] kk);
        if (DESC != 0)
            return IW'(DCNT - 1) - kk;
        else
            return kk;
    endfunction

    assign o_vld = (state == SEND);

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        advance   = 1'b0;
        xfer      = o_vld & i_rdy;
        o_rdy     = (state == IDLE) | (i_rdy & o_last);
        capture   = i_vld & o_rdy;
        drop      = i_vld & ~o_rdy;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = SEND;
                    k_nxt     = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!o_last) begin
                        k_nxt   = k + IW'(1);
                        advance = 1'b1;
                    end else if (i_vld) begin
                        k_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Output word registers are loaded one step ahead so they are stable during stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold   <= '0;
            o_data <= '0;
            o_idx  <= '0;
            o_last <= 1'b0;
        end else if (capture) begin
            hold   <= i_data;
            o_data <= i_data[idx_of('0)];
            o_idx  <= idx_of('0);
            o_last <= (KCNT == 1);
        end else if (advance) begin
            o_data <= hold[idx_of(k_nxt)];
            o_idx  <= idx_of(k_nxt);
            o_last <= (k_nxt == IW'(KCNT - 1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_drop     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_drop <= drop;
            if (drop && (o_drop_cnt != {CNT_W{1'b1}}))
                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
        end
    end

endmodule
